pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the generalised successor of the EX/MEM latch. It carries a configurable payload: destination register, write data, HI/LO, ALU op, memory address and store operand. It also carries a valid bit and multi-cycle arithmetic state (accumulator plus cycle counter for madd/msub-style ops). It obeys the global stall vector at a configurable stage index, adds a flush input with highest non-reset priority, and reports a saturating stall-hold counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_reg                                               |
// | Description : Parametrised inter-stage pipeline register with flush,      |
// |               stall-vector control, multi-cycle state carry and a          |
// |               saturating stall-hold counter.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 8,
  parameter int ACC_W   = 64,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int STAGE   = 3,
  parameter int HOLD_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_wd,
  input  logic               in_wreg,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [DATA_W-1:0]  in_hi,
  input  logic [DATA_W-1:0]  in_lo,
  input  logic               in_whilo,
  input  logic [OP_W-1:0]    in_aluop,
  input  logic [DATA_W-1:0]  in_mem_addr,
  input  logic [DATA_W-1:0]  in_reg2,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_wd,
  output logic               out_wreg,
  output logic [DATA_W-1:0]  out_wdata,
  output logic [DATA_W-1:0]  out_hi,
  output logic [DATA_W-1:0]  out_lo,
  output logic               out_whilo,
  output logic [OP_W-1:0]    out_aluop,
  output logic [DATA_W-1:0]  out_mem_addr,
  output logic [DATA_W-1:0]  out_reg2,
  output logic [ACC_W-1:0]   acc_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [HOLD_W-1:0]  hold_cnt
);

  localparam int              c_PAY_W    = 1 + ADDR_W + 1 + 5 * DATA_W + 1 + OP_W;
  localparam logic [HOLD_W-1:0] c_HOLD_MAX = '1;

  generate
    if (STAGE + 1 >= STALL_W) begin : g_bad_stage
      $error("pipe_stage_reg: STAGE+1 must be below STALL_W");
    end
  endgenerate

  logic               w_up_stall;
  logic               w_dn_stall;
  logic               w_stall_unused;
  logic [c_PAY_W-1:0] w_in_payload;
  logic [HOLD_W-1:0]  w_hold_next;

  logic [c_PAY_W-1:0] r_payload;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [HOLD_W-1:0]  r_hold;

  assign w_up_stall     = stall[STAGE];
  assign w_dn_stall     = stall[STAGE+1];
  // Only two bits of the global vector concern this stage.
  assign w_stall_unused = ^stall;

  assign w_in_payload = {in_valid, in_wd, in_wreg, in_wdata, in_hi, in_lo,
                         in_whilo, in_aluop, in_mem_addr, in_reg2};

  assign w_hold_next = (r_hold == c_HOLD_MAX) ? r_hold : r_hold + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_payload <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
    end else if (flush) begin
      r_payload <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
    end else if (w_up_stall && !w_dn_stall) begin
      // Downstream keeps moving while upstream is stuck: emit a bubble but
      // keep the multi-cycle arithmetic state looping back upstream.
      r_payload <= '0;
      r_acc     <= acc_i;
      r_cnt     <= cnt_i;
      r_hold    <= w_hold_next;
    end else if (!w_up_stall) begin
      r_payload <= w_in_payload;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_hold    <= '0;
    end else begin
      r_acc     <= acc_i;
      r_cnt     <= cnt_i;
      r_hold    <= w_hold_next;
    end
  end

  assign {out_valid, out_wd, out_wreg, out_wdata, out_hi, out_lo,
          out_whilo, out_aluop, out_mem_addr, out_reg2} = r_payload;

  assign acc_o    = r_acc;
  assign cnt_o    = r_cnt;
  assign hold_cnt = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_reg                                            |
// | Description : Scoreboard bench for pipe_stage_reg with a reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_reg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 8;
  localparam int ACC_W   = 64;
  localparam int CNT_W   = 2;
  localparam int STALL_W = 6;
  localparam int STAGE   = 3;
  localparam int HOLD_W  = 4;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              whilo;
    logic [OP_W-1:0]   aluop;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] reg2;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [ADDR_W-1:0]  in_wd;
  logic               in_wreg;
  logic [DATA_W-1:0]  in_wdata;
  logic [DATA_W-1:0]  in_hi;
  logic [DATA_W-1:0]  in_lo;
  logic               in_whilo;
  logic [OP_W-1:0]    in_aluop;
  logic [DATA_W-1:0]  in_mem_addr;
  logic [DATA_W-1:0]  in_reg2;
  logic [ACC_W-1:0]   acc_i;
  logic [CNT_W-1:0]   cnt_i;
  logic               out_valid;
  logic [ADDR_W-1:0]  out_wd;
  logic               out_wreg;
  logic [DATA_W-1:0]  out_wdata;
  logic [DATA_W-1:0]  out_hi;
  logic [DATA_W-1:0]  out_lo;
  logic               out_whilo;
  logic [OP_W-1:0]    out_aluop;
  logic [DATA_W-1:0]  out_mem_addr;
  logic [DATA_W-1:0]  out_reg2;
  logic [ACC_W-1:0]   acc_o;
  logic [CNT_W-1:0]   cnt_o;
  logic [HOLD_W-1:0]  hold_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t model    = '0;
  exp_t sb_q[$];

  pipe_stage_reg #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W), .ACC_W(ACC_W),
    .CNT_W(CNT_W), .STALL_W(STALL_W), .STAGE(STAGE), .HOLD_W(HOLD_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_hi(in_hi), .in_lo(in_lo), .in_whilo(in_whilo),
    .in_aluop(in_aluop), .in_mem_addr(in_mem_addr), .in_reg2(in_reg2),
    .acc_i(acc_i), .cnt_i(cnt_i),
    .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg),
    .out_wdata(out_wdata), .out_hi(out_hi), .out_lo(out_lo),
    .out_whilo(out_whilo), .out_aluop(out_aluop),
    .out_mem_addr(out_mem_addr), .out_reg2(out_reg2),
    .acc_o(acc_o), .cnt_o(cnt_o), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected next state from the current one and the inputs now applied.
  function automatic exp_t model_next(input exp_t cur);
    exp_t n;
    logic [HOLD_W-1:0] sat;
    n   = cur;
    sat = (cur.hold == {HOLD_W{1'b1}}) ? cur.hold : cur.hold + 1'b1;
    if (!rst || flush) begin
      n = '0;
    end else if (stall[STAGE] && !stall[STAGE+1]) begin
      n      = '0;
      n.acc  = acc_i;
      n.cnt  = cnt_i;
      n.hold = sat;
    end else if (!stall[STAGE]) begin
      n.valid = in_valid;  n.wd = in_wd;  n.wreg = in_wreg;
      n.wdata = in_wdata;  n.hi = in_hi;  n.lo = in_lo;
      n.whilo = in_whilo;  n.aluop = in_aluop;
      n.mem_addr = in_mem_addr;  n.reg2 = in_reg2;
      n.acc = '0;  n.cnt = '0;  n.hold = '0;
    end else begin
      n.acc  = acc_i;
      n.cnt  = cnt_i;
      n.hold = sat;
    end
    return n;
  endfunction

  task automatic cycle(input string tag);
    exp_t e;
    model = model_next(model);
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, ".valid"},    64'(out_valid),    64'(e.valid));
      check_val({tag, ".wd"},       64'(out_wd),       64'(e.wd));
      check_val({tag, ".wreg"},     64'(out_wreg),     64'(e.wreg));
      check_val({tag, ".wdata"},    64'(out_wdata),    64'(e.wdata));
      check_val({tag, ".hi"},       64'(out_hi),       64'(e.hi));
      check_val({tag, ".lo"},       64'(out_lo),       64'(e.lo));
      check_val({tag, ".whilo"},    64'(out_whilo),    64'(e.whilo));
      check_val({tag, ".aluop"},    64'(out_aluop),    64'(e.aluop));
      check_val({tag, ".mem_addr"}, 64'(out_mem_addr), 64'(e.mem_addr));
      check_val({tag, ".reg2"},     64'(out_reg2),     64'(e.reg2));
      check_val({tag, ".acc"},      64'(acc_o),        64'(e.acc));
      check_val({tag, ".cnt"},      64'(cnt_o),        64'(e.cnt));
      check_val({tag, ".hold"},     64'(hold_cnt),     64'(e.hold));
    end
  endtask

  task automatic rand_inputs();
    in_valid    = 1'($urandom);
    in_wd       = ADDR_W'($urandom);
    in_wreg     = 1'($urandom);
    in_wdata    = $urandom;
    in_hi       = $urandom;
    in_lo       = $urandom;
    in_whilo    = 1'($urandom);
    in_aluop    = OP_W'($urandom);
    in_mem_addr = $urandom;
    in_reg2     = $urandom;
    acc_i       = {$urandom, $urandom};
    cnt_i       = CNT_W'($urandom);
  endtask

  initial begin
    // Reset with every input driven high.
    rst = 1'b0;  flush = 1'b1;  stall = '0;
    flush = 1'b0;
    in_valid = 1'b1;  in_wd = '1;  in_wreg = 1'b1;  in_wdata = '1;
    in_hi = '1;  in_lo = '1;  in_whilo = 1'b1;  in_aluop = '1;
    in_mem_addr = '1;  in_reg2 = '1;  acc_i = '1;  cnt_i = '1;
    cycle("reset0");
    cycle("reset1");
    check_val("reset.hold_cnt", 64'(hold_cnt), 64'd0);
    check_val("reset.wdata", 64'(out_wdata), 64'd0);

    // Pass-through.
    rst = 1'b1;
    rand_inputs();
    in_wd = 5'd7;  in_wdata = 32'hDEADBEEF;  in_aluop = 8'h21;  in_valid = 1'b1;
    cycle("pass");
    check_val("pass.wd", 64'(out_wd), 64'd7);
    check_val("pass.wdata", 64'(out_wdata), 64'hDEADBEEF);
    check_val("pass.aluop", 64'(out_aluop), 64'h21);
    check_val("pass.acc", 64'(acc_o), 64'd0);

    // Bubble carrying multi-cycle state, then release.
    stall = 6'b001111;  acc_i = 64'h0000_0001_0000_0002;  cnt_i = 2'b01;
    cycle("bubble");
    check_val("bubble.acc", 64'(acc_o), 64'h0000_0001_0000_0002);
    check_val("bubble.hold", 64'(hold_cnt), 64'd1);
    check_val("bubble.valid", 64'(out_valid), 64'd0);
    stall = 6'b000000;
    cycle("release");
    check_val("release.cnt", 64'(cnt_o), 64'd0);

    // Hold with both stalled.
    in_wdata = 32'h12345678;  in_valid = 1'b1;
    cycle("load");
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cycle("hold");
      check_val("hold.wdata", 64'(out_wdata), 64'h12345678);
      check_val("hold.count", 64'(hold_cnt), 64'(i + 1));
    end

    // Saturation.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      cycle("sat");
    end
    check_val("sat.hold", 64'(hold_cnt), 64'd15);

    // Flush beats stall.
    stall = 6'b000000;  rand_inputs();  in_valid = 1'b1;
    cycle("pre_flush");
    stall = 6'b011111;  rand_inputs();
    cycle("flush_hold");
    flush = 1'b1;  rand_inputs();
    cycle("flush");
    check_val("flush.valid", 64'(out_valid), 64'd0);
    check_val("flush.acc", 64'(acc_o), 64'd0);
    check_val("flush.hold", 64'(hold_cnt), 64'd0);
    flush = 1'b0;  stall = 6'b000000;  rand_inputs();  in_valid = 1'b1;
    cycle("reload");
    stall = 6'b011111;  rand_inputs();
    cycle("rehold");
    rst = 1'b0;  flush = 1'b1;
    cycle("rst_flush");
    check_val("rst_flush.acc", 64'(acc_o), 64'd0);
    rst = 1'b1;  flush = 1'b0;

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      rand_inputs();
      stall = STALL_W'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 19) != 0);
      cycle("rand");
    end

    check_val("sb.drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
